// File: rtl/seg_pkg.sv
// Shared types and constants for the segment serial shifter.
// Imported by the shifter top and its phase-tick sub-module.
package seg_pkg;

  localparam int SEG_DIGITS  = 8;
  localparam int SEG_BITS    = 8;
  localparam int SEG_FRAME_W = SEG_DIGITS * SEG_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } seg_state_e;

  function automatic int seg_cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seg_p2s_tick.sv
// Phase timer: one-cycle phase_end every HALF_PERIOD cycles while en.
// Held at zero whenever disabled.
module seg_p2s_tick
  import seg_pkg::*;
#(
  parameter int HALF_PERIOD = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic phase_end
);

  localparam int CW = seg_cnt_w(HALF_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign phase_end = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!en || phase_end) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg_p2s_shifter.sv
// Serialises a segment frame into external SIPO registers,
// driving shift clock, data, latch strobe and clear.
module seg_p2s_shifter
  import seg_pkg::*;
#(
  parameter int WIDTH       = SEG_FRAME_W,
  parameter int HALF_PERIOD = 2,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] par_data,
  output logic             s_clk,
  output logic             s_data,
  output logic             s_clr_n,
  output logic             s_pen,
  output logic             busy,
  output logic             done
);

  localparam int BW = seg_cnt_w(WIDTH);

  seg_state_e       state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             s_clk_q, s_clk_d;
  logic             s_data_q, s_data_d;
  logic             s_clr_n_q, s_clr_n_d;
  logic             s_pen_q, s_pen_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             phase_end;
  logic [WIDTH-1:0] sr_shift;
  logic             first_bit, next_bit;

  seg_p2s_tick #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (state_q != IDLE),
    .phase_end(phase_end)
  );

  assign first_bit = MSB_FIRST ? par_data[WIDTH-1] : par_data[0];
  assign sr_shift  = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0}
                               : {1'b0, sr_q[WIDTH-1:1]};
  assign next_bit  = MSB_FIRST ? sr_q[WIDTH-2] : sr_q[1];

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    s_clk_d   = s_clk_q;
    s_data_d  = s_data_q;
    s_clr_n_d = 1'b1;
    s_pen_d   = s_pen_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sr_d      = par_data;
          bit_cnt_d = BW'(WIDTH);
          s_clk_d   = 1'b0;
          s_data_d  = first_bit;
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (phase_end) begin
          if (!s_clk_q) begin
            s_clk_d = 1'b1;
          end else begin
            s_clk_d = 1'b0;
            // last bit: keep s_data on it and go strobe the latch
            if (bit_cnt_q == BW'(1)) begin
              s_pen_d = 1'b1;
              state_d = LATCH;
            end else begin
              sr_d      = sr_shift;
              s_data_d  = next_bit;
              bit_cnt_d = bit_cnt_q - 1'b1;
            end
          end
        end
      end
      LATCH: begin
        if (phase_end) begin
          s_pen_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      s_clk_q   <= 1'b0;
      s_data_q  <= 1'b0;
      s_clr_n_q <= 1'b0;
      s_pen_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      s_clk_q   <= s_clk_d;
      s_data_q  <= s_data_d;
      s_clr_n_q <= s_clr_n_d;
      s_pen_q   <= s_pen_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign s_clk   = s_clk_q;
  assign s_data  = s_data_q;
  assign s_clr_n = s_clr_n_q;
  assign s_pen   = s_pen_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
